// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus bridge: window base, state encoding,
// timeout defaults, register-index width and the latched request record.
// Optional timeout support is selected in the bridge by BUS_TIMEOUT_EN.
package cpu_bus_pkg;

  localparam int REG_IDX_W = 5;
  localparam int REG_COUNT = 1 << REG_IDX_W;

  localparam logic [31-REG_IDX_W:0] DEFAULT_REGFILE_BASE   = 27'h7000000;
  localparam int                    DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [31:0]           DEFAULT_ERROR_DATA     = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    IDLE,
    REG_ACCESS,
    MEM_REQUEST,
    MEM_WAIT,
    RESPOND
  } busState_t;

  // Everything the CPU presents with cpuTransactionBegin, held for the whole access.
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [3:0]  writeMask;
  } cpuReq_t;

  // True when the address falls inside the 32-word register file window.
  function automatic logic inRegWindow(input logic [31:0] address,
                                       input logic [31-REG_IDX_W:0] base);
    return address[31:REG_IDX_W] == base;
  endfunction

endpackage

// File: rtl/cpu_register_file.sv
// 32 x 32-bit general-purpose register file, entry 0 reads as zero.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none, always ready; cleared synchronously by rst.
module cpu_register_file
  import cpu_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 writeEnable,
  input  logic [REG_IDX_W-1:0] writeIndex,
  input  logic [31:0]          writeData,
  input  logic [REG_IDX_W-1:0] readIndex,
  output logic [31:0]          readData
);

  logic [31:0] regs [REG_COUNT];

  // Clear everything on reset; otherwise full-word writes, index 0 discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEnable && (writeIndex != '0)) begin
      regs[writeIndex] <= writeData;
    end
  end

  assign readData = (readIndex == '0) ? 32'h0 : regs[readIndex];

endmodule

// File: rtl/cpu_bus_bridge.sv
// CPU bus bridge: serves the register window locally, forwards the rest to memory.
// Latency: register access ends at N+2, memory access ends one cycle after memAcknowledge.
// Backpressure: begins are honoured only in IDLE; memRequest holds until acknowledged.
// BUS_TIMEOUT_EN adds a memAcknowledge timeout with ERROR_DATA reads and a sticky busError.
module cpu_bus_bridge
  import cpu_bus_pkg::*;
#(
`ifdef BUS_TIMEOUT_EN
  parameter int                    TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [31:0]           ERROR_DATA     = DEFAULT_ERROR_DATA,
`endif
  parameter logic [31-REG_IDX_W:0] REGFILE_BASE   = DEFAULT_REGFILE_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpuAddress,
  input  logic [31:0] cpuWriteData,
  input  logic        cpuWriteEnable,
  input  logic [3:0]  cpuWriteMask,
  input  logic        cpuTransactionBegin,
  output logic [31:0] cpuReadData,
  output logic        cpuTransactionEnd,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWriteEnable,
  output logic [3:0]  memWriteMask,
  output logic        memRequest,
  input  logic        memAcknowledge,
  input  logic [31:0] memReadData
`ifdef BUS_TIMEOUT_EN
  ,
  output logic        busError
`endif
);

  busState_t   state;
  busState_t   stateNext;
  cpuReq_t     req;
  logic        timeoutHit;
  logic        rfWrite;
  logic [31:0] rfReadData;

  // Register the FSM state; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (cpuTransactionBegin) begin
          stateNext = inRegWindow(cpuAddress, REGFILE_BASE) ? REG_ACCESS : MEM_REQUEST;
        end
      end
      REG_ACCESS:  stateNext = RESPOND;
      MEM_REQUEST: stateNext = MEM_WAIT;
      MEM_WAIT: begin
        // An acknowledge in the expiry cycle still counts as a normal completion.
        if (memAcknowledge || timeoutHit) begin
          stateNext = RESPOND;
        end
      end
      RESPOND:     stateNext = IDLE;
      default:     stateNext = IDLE;
    endcase
  end

  // Outputs decoded from state; memory fields stay zero while no request is open.
  always_comb begin
    cpuTransactionEnd = (state == RESPOND);
    memRequest        = (state == MEM_REQUEST) || (state == MEM_WAIT);
    memAddress        = memRequest ? req.address     : 32'h0;
    memWriteData      = memRequest ? req.writeData   : 32'h0;
    memWriteEnable    = memRequest ? req.writeEnable : 1'b0;
    memWriteMask      = memRequest ? req.writeMask   : 4'h0;
    rfWrite           = (state == REG_ACCESS) && req.writeEnable;
  end

  // Latch the request on an accepted begin and capture read results into cpuReadData.
  always_ff @(posedge clk) begin
    if (rst) begin
      req         <= '0;
      cpuReadData <= '0;
    end else begin
      if ((state == IDLE) && cpuTransactionBegin) begin
        req <= '{address:     cpuAddress,
                 writeData:   cpuWriteData,
                 writeEnable: cpuWriteEnable,
                 writeMask:   cpuWriteMask};
      end
      if ((state == REG_ACCESS) && !req.writeEnable) begin
        cpuReadData <= rfReadData;
      end
      if ((state == MEM_WAIT) && !req.writeEnable) begin
        if (memAcknowledge) begin
          cpuReadData <= memReadData;
        end
`ifdef BUS_TIMEOUT_EN
        else if (timeoutHit) begin
          cpuReadData <= ERROR_DATA;
        end
`endif
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] waitCount;

  // Count MEM_WAIT cycles; expiry fires on the last allowed cycle without an acknowledge.
  assign timeoutHit = (state == MEM_WAIT) && !memAcknowledge &&
                      (waitCount == TO_W'(TIMEOUT_CYCLES - 1));

  // Wait counter and sticky error flag; only rst clears busError.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCount <= '0;
      busError  <= 1'b0;
    end else begin
      waitCount <= (state == MEM_WAIT) ? waitCount + 1'b1 : '0;
      if (timeoutHit) begin
        busError <= 1'b1;
      end
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  cpu_register_file regFile (
    .clk        (clk),
    .rst        (rst),
    .writeEnable(rfWrite),
    .writeIndex (req.address[REG_IDX_W-1:0]),
    .writeData  (req.writeData),
    .readIndex  (req.address[REG_IDX_W-1:0]),
    .readData   (rfReadData)
  );

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge with a configurable memory responder.
// Latency is counted in falling edges after the edge that samples the begin.
// Build with BUS_TIMEOUT_EN defined to also exercise the timeout path.
module tb_cpu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpuAddress;
  logic [31:0] cpuWriteData;
  logic        cpuWriteEnable;
  logic [3:0]  cpuWriteMask;
  logic        cpuTransactionBegin;
  logic [31:0] cpuReadData;
  logic        cpuTransactionEnd;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWriteEnable;
  logic [3:0]  memWriteMask;
  logic        memRequest;
  logic        memAcknowledge;
  logic [31:0] memReadData;
`ifdef BUS_TIMEOUT_EN
  logic        busError;
`endif

  int checks   = 0;
  int failures = 0;

  // Responder configuration: acknowledge once memRequest has been seen ackDelay+1 cycles; -1 = never.
  int          ackDelay = -1;
  logic [31:0] respData = 32'h0;
  int          reqCnt   = 0;

  // Observations from the last runTxn.
  int          obsLat;
  int          obsEnds;
  logic [31:0] endData;
  logic [31:0] snapAddr;
  logic [31:0] snapData;
  logic        snapWe;
  logic [3:0]  snapMask;
  logic        snapStable;
  logic        snapSeen;
  logic        reqAtEnd;

  always #5 clk = ~clk;

  cpu_bus_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .cpuAddress         (cpuAddress),
    .cpuWriteData       (cpuWriteData),
    .cpuWriteEnable     (cpuWriteEnable),
    .cpuWriteMask       (cpuWriteMask),
    .cpuTransactionBegin(cpuTransactionBegin),
    .cpuReadData        (cpuReadData),
    .cpuTransactionEnd  (cpuTransactionEnd),
    .memAddress         (memAddress),
    .memWriteData       (memWriteData),
    .memWriteEnable     (memWriteEnable),
    .memWriteMask       (memWriteMask),
    .memRequest         (memRequest),
    .memAcknowledge     (memAcknowledge),
    .memReadData        (memReadData)
`ifdef BUS_TIMEOUT_EN
    ,
    .busError           (busError)
`endif
  );

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model driven on the falling edge.
  initial begin
    memAcknowledge = 1'b0;
    memReadData    = 32'h0;
    forever begin
      @(negedge clk);
      if (memRequest) reqCnt++;
      else            reqCnt = 0;
      memAcknowledge = (ackDelay >= 0) && memRequest && (reqCnt >= ackDelay + 1);
      memReadData    = respData;
    end
  end

  // One CPU transaction; optionally pulses a second begin at falling edge rebeginAt.
  task automatic runTxn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                        input logic [3:0] mask, input int rebeginAt, input int limit);
    @(negedge clk);
    cpuAddress          = addr;
    cpuWriteData        = wdata;
    cpuWriteEnable      = we;
    cpuWriteMask        = mask;
    cpuTransactionBegin = 1'b1;
    obsLat     = 0;
    obsEnds    = 0;
    endData    = 32'h0;
    snapSeen   = 1'b0;
    snapStable = 1'b1;
    reqAtEnd   = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == rebeginAt) begin
        cpuAddress          = 32'hE000_0007;
        cpuWriteData        = 32'h0000_0055;
        cpuWriteEnable      = 1'b1;
        cpuTransactionBegin = 1'b1;
      end else begin
        cpuTransactionBegin = 1'b0;
      end
      if (memRequest) begin
        if (!snapSeen) begin
          snapSeen = 1'b1;
          snapAddr = memAddress;
          snapData = memWriteData;
          snapWe   = memWriteEnable;
          snapMask = memWriteMask;
        end else if (memAddress !== snapAddr || memWriteData !== snapData ||
                     memWriteEnable !== snapWe || memWriteMask !== snapMask) begin
          snapStable = 1'b0;
        end
      end
      if (cpuTransactionEnd) begin
        obsEnds++;
        if (obsLat == 0) begin
          obsLat   = k;
          endData  = cpuReadData;
          reqAtEnd = memRequest;
        end
      end
      if (obsLat != 0 && k >= obsLat + 3) break;
    end
    cpuTransactionBegin = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cpuAddress = '0; cpuWriteData = '0; cpuWriteEnable = 1'b0;
    cpuWriteMask = '0; cpuTransactionBegin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    checkEq("rst_end", 32'(cpuTransactionEnd), 32'd0);
    checkEq("rst_req", 32'(memRequest), 32'd0);
    checkEq("rst_rdata", cpuReadData, 32'h0);
    checkEq("rst_maddr", memAddress, 32'h0);
`ifdef BUS_TIMEOUT_EN
    checkEq("rst_buserr", 32'(busError), 32'd0);
`endif

    // Register window write then read of index 5.
    runTxn(32'hE000_0005, 32'h1234_5678, 1'b1, 4'h0, 0, 40);
    checkEq("reg_wr_lat", obsLat, 2);
    checkEq("reg_wr_ends", obsEnds, 1);
    checkEq("reg_wr_noreq", 32'(snapSeen), 32'd0);
    runTxn(32'hE000_0005, 32'h0, 1'b0, 4'h0, 0, 40);
    checkEq("reg_rd_lat", obsLat, 2);
    checkEq("reg_rd_data", endData, 32'h1234_5678);

    // Index 0 discards writes and reads zero; the write keeps the previous read data.
    runTxn(32'hE000_0000, 32'hFFFF_FFFF, 1'b1, 4'hF, 0, 40);
    checkEq("r0_wr_hold", endData, 32'h1234_5678);
    runTxn(32'hE000_0000, 32'h0, 1'b0, 4'h0, 0, 40);
    checkEq("r0_rd_data", endData, 32'h0);

    // Memory read, acknowledge 3 cycles after memRequest rises.
    ackDelay = 3; respData = 32'hCAFE_F00D;
    runTxn(32'h0000_1000, 32'h0, 1'b0, 4'h0, 0, 40);
    checkEq("mrd_lat", obsLat, 5);
    checkEq("mrd_data", endData, 32'hCAFE_F00D);
    checkEq("mrd_req_at_end", 32'(reqAtEnd), 32'd0);
    checkEq("mrd_addr", snapAddr, 32'h0000_1000);
    checkEq("mrd_we", 32'(snapWe), 32'd0);

    // Minimum memory latency: acknowledge already high in the first wait cycle.
    ackDelay = 1; respData = 32'h0BAD_F00D;
    runTxn(32'h0000_1004, 32'h0, 1'b0, 4'h0, 0, 40);
    checkEq("mrd_min_lat", obsLat, 3);
    checkEq("mrd_min_data", endData, 32'h0BAD_F00D);

    // Masked store held stable until acknowledge.
    ackDelay = 2; respData = 32'h1111_2222;
    runTxn(32'h0000_0010, 32'h0000_BEEF, 1'b1, 4'b0011, 0, 40);
    checkEq("mwr_lat", obsLat, 4);
    checkEq("mwr_we", 32'(snapWe), 32'd1);
    checkEq("mwr_mask", 32'(snapMask), 32'h3);
    checkEq("mwr_data", snapData, 32'h0000_BEEF);
    checkEq("mwr_addr", snapAddr, 32'h0000_0010);
    checkEq("mwr_stable", 32'(snapStable), 32'd1);
    checkEq("mwr_rdata_hold", endData, 32'h0BAD_F00D);
    runTxn(32'hE000_0010, 32'h0, 1'b0, 4'h0, 0, 40);
    checkEq("mwr_rf_r16", endData, 32'h0);
    runTxn(32'hE000_0005, 32'h0, 1'b0, 4'h0, 0, 40);
    checkEq("mwr_rf_r5", endData, 32'h1234_5678);

    // Second begin during MEM_WAIT is ignored.
    ackDelay = 3; respData = 32'hA5A5_5A5A;
    runTxn(32'h0000_2000, 32'h0, 1'b0, 4'h0, 3, 40);
    checkEq("rebegin_ends", obsEnds, 1);
    checkEq("rebegin_lat", obsLat, 5);
    checkEq("rebegin_data", endData, 32'hA5A5_5A5A);
    runTxn(32'hE000_0007, 32'h0, 1'b0, 4'h0, 0, 40);
    checkEq("rebegin_r7", endData, 32'h0);

`ifdef BUS_TIMEOUT_EN
    // No acknowledge: 255 wait cycles, then end with error data.
    ackDelay = -1;
    runTxn(32'h0000_3000, 32'h0, 1'b0, 4'h0, 0, 400);
    checkEq("to_lat", obsLat, 257);
    checkEq("to_data", endData, 32'hDEAD_BEEF);
    checkEq("to_req_at_end", 32'(reqAtEnd), 32'd0);
    repeat (5) @(negedge clk);
    checkEq("to_buserr_sticky", 32'(busError), 32'd1);
`endif

    // Reset while waiting for an acknowledge.
    begin
      int endsSeen;
      ackDelay = -1;
      endsSeen = 0;
      @(negedge clk);
      cpuAddress = 32'h0000_4000; cpuWriteEnable = 1'b0; cpuTransactionBegin = 1'b1;
      @(negedge clk);
      cpuTransactionBegin = 1'b0;
      repeat (2) @(negedge clk);
      checkEq("abort_req_before", 32'(memRequest), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      checkEq("abort_req", 32'(memRequest), 32'd0);
      checkEq("abort_rdata", cpuReadData, 32'h0);
      if (cpuTransactionEnd) endsSeen++;
      rst = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (cpuTransactionEnd) endsSeen++;
      end
      checkEq("abort_no_end", endsSeen, 0);
`ifdef BUS_TIMEOUT_EN
      checkEq("abort_buserr_clr", 32'(busError), 32'd0);
`endif
    end
    runTxn(32'hE000_0005, 32'h0, 1'b0, 4'h0, 0, 40);
    checkEq("abort_r5_lat", obsLat, 2);
    checkEq("abort_r5", endData, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
